// File: rtl/mexiko_pkg.sv
// Shared reset-sequencer types: FSM state encodings and a small constant helper.
package mexiko_pkg;

   typedef enum logic [2:0] {
      HOLD     = 3'd0,
      NET_WAIT = 3'd1,
      RUN      = 3'd2,
      FAIL     = 3'd3
   } rst_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cdc_sync.sv
// Single-bit flop-chain synchronizer with asynchronous reset to a selectable value.
module cdc_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // STAGES must be at least 2 for metastability settling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= {STAGES{RESET_VAL}};
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Board reset sequencer: holds the network block, waits for its resetdone, then releases the SoC.
// Define RST_SEQ_RETRY_EN to retry forever after a resetdone timeout instead of parking in FAIL.
module rst_seq
   import mexiko_pkg::*;
#(
   parameter int HOLD_CYCLES  = 1024,
   parameter int DONE_TIMEOUT = 1048576,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       sys_clk_i,
   input  logic       areset_i,
   input  logic       net_resetdone_i,
   output logic       net_rst_o,
   output logic       sys_rst_o,
   output logic       sys_rst_n_o,
   output logic       ready_o,
   output logic       timeout_o,
   output logic [2:0] state_o
);

   localparam int CNT_W = max_int(1, $clog2(max_int(HOLD_CYCLES, DONE_TIMEOUT)));
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_ARM  = CNT_W'((HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0);
   localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);

   rst_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             rst_int;
   logic             done_sync;
   logic             done_clr;

   cdc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_rst_sync (
      .clk (sys_clk_i),
      .rst (areset_i),
      .d   (1'b0),
      .q   (rst_int)
   );

   // The resetdone synchronizer is kept clear while the network is in reset so a stale
   // resetdone cannot leak through; it is armed one cycle before leaving HOLD so a
   // resetdone that is already high is seen exactly SYNC_STAGES edges after net_rst_o falls.
   cdc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_done_sync (
      .clk (sys_clk_i),
      .rst (done_clr),
      .d   (net_resetdone_i),
      .q   (done_sync)
   );

   always_ff @(posedge sys_clk_i or posedge rst_int) begin
      if (rst_int) begin
         state       <= HOLD;
         cnt         <= '0;
         net_rst_o   <= 1'b1;
         sys_rst_o   <= 1'b1;
         sys_rst_n_o <= 1'b0;
         ready_o     <= 1'b0;
         timeout_o   <= 1'b0;
         done_clr    <= 1'b1;
      end else begin
         case (state)
            HOLD: begin
               if (cnt == HOLD_ARM) begin
                  done_clr <= 1'b0;
               end
               if (cnt == HOLD_LAST) begin
                  cnt       <= '0;
                  state     <= NET_WAIT;
                  net_rst_o <= 1'b0;
                  done_clr  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            NET_WAIT: begin
               // resetdone is tested first so it wins over a simultaneous timeout.
               if (done_sync) begin
                  cnt         <= '0;
                  state       <= RUN;
                  sys_rst_o   <= 1'b0;
                  sys_rst_n_o <= 1'b1;
                  ready_o     <= 1'b1;
               end else if (cnt == DONE_LAST) begin
                  cnt       <= '0;
                  timeout_o <= 1'b1;
                  net_rst_o <= 1'b1;
                  done_clr  <= 1'b1;
`ifdef RST_SEQ_RETRY_EN
                  state     <= HOLD;
`else
                  state     <= FAIL;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               if (!done_sync) begin
                  cnt         <= '0;
                  state       <= HOLD;
                  net_rst_o   <= 1'b1;
                  sys_rst_o   <= 1'b1;
                  sys_rst_n_o <= 1'b0;
                  ready_o     <= 1'b0;
                  done_clr    <= 1'b1;
               end
            end
            FAIL: begin
               net_rst_o <= 1'b1;
               sys_rst_o <= 1'b1;
            end
            default: begin
               cnt         <= '0;
               state       <= HOLD;
               net_rst_o   <= 1'b1;
               sys_rst_o   <= 1'b1;
               sys_rst_n_o <= 1'b0;
               ready_o     <= 1'b0;
               done_clr    <= 1'b1;
            end
         endcase
      end
   end

   assign state_o = state;

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1024, meaning cycles of reset hold after internal reset release.
REQ-002 SHALL have parameter DONE_TIMEOUT, default 1048576, meaning max cycles to wait for network resetdone.
REQ-003 SHALL have parameter SYNC_STAGES, default 2 (min 2), meaning flop depth of every synchronizer.
REQ-004 SHALL have port sys_clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port areset_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port net_resetdone_i, input, 1 bit: network resetdone, asynchronous to sys_clk_i.
REQ-007 SHALL have port net_rst_o, output, 1 bit: active-high reset to the network block.
REQ-008 SHALL have port sys_rst_o, output, 1 bit: active-high reset to SoC/DDR3/PCIe logic.
REQ-009 SHALL have port sys_rst_n_o, output, 1 bit: exact complement of sys_rst_o.
REQ-010 SHALL have port ready_o, output, 1 bit: high only in RUN.
REQ-011 SHALL have port timeout_o, output, 1 bit: sticky flag for any resetdone timeout.
REQ-012 SHALL have port state_o, output, 3 bits: current state encoding, for debug LEDs.

Function
REQ-013 SHALL implement FSM states HOLD=0, NET_WAIT=1, RUN=2, FAIL=3, all outputs registered.
REQ-014 HOLD: counter increments each cycle; at count HOLD_CYCLES-1, SHALL clear the counter, enter NET_WAIT and deassert net_rst_o on that edge.
REQ-015 NET_WAIT: when synchronized resetdone is 1, SHALL enter RUN and deassert sys_rst_o and assert ready_o on the same edge.
REQ-016 NET_WAIT: counter increments each cycle; at count DONE_TIMEOUT-1 without resetdone, SHALL set timeout_o and take the REQ-024 path.
REQ-017 If resetdone and timeout occur in the same cycle, resetdone SHALL win.
REQ-018 RUN: if synchronized resetdone falls to 0, SHALL assert net_rst_o and sys_rst_o, deassert ready_o and enter HOLD with counter 0 on the next edge.
REQ-019 Counters SHALL be sized $clog2(max(HOLD_CYCLES,DONE_TIMEOUT)) bits and SHALL never wrap.
REQ-020 Synchronized resetdone SHALL lag net_resetdone_i by exactly SYNC_STAGES edges.

Reset
REQ-021 areset_i assertion SHALL immediately and asynchronously force net_rst_o=1, sys_rst_o=1, sys_rst_n_o=0, ready_o=0, timeout_o=0, state_o=HOLD, counters=0.
REQ-022 areset_i deassertion SHALL be released internally through a SYNC_STAGES flop chain; the FSM SHALL first count on the edge after release.
REQ-023 areset_i asserted in any state mid-sequence SHALL restart the full sequence from REQ-021.

Configuration
REQ-024 With RST_SEQ_RETRY_EN defined, a timeout SHALL return to HOLD (net_rst_o=1, counter 0) and retry indefinitely; without it, a timeout SHALL enter FAIL, hold net_rst_o=1 and sys_rst_o=1, and leave FAIL only via areset_i.

Structure
REQ-025 The state enum rst_state_t and its encodings SHALL live in shared package mexiko_pkg.
REQ-026 Synchronizers SHALL be instances of sub-module cdc_sync (parameter STAGES, asynchronous reset value parameter), used for both reset release and resetdone.

Verification (HOLD_CYCLES=8, DONE_TIMEOUT=32, SYNC_STAGES=2)
REQ-027 Deassert areset_i, hold net_resetdone_i=1 -> net_rst_o falls 10 edges after release; sys_rst_o falls and ready_o rises 2 edges after that; state_o goes 0->1->2.
REQ-028 Hold net_resetdone_i=0 -> after 32 cycles in NET_WAIT, timeout_o=1; with RST_SEQ_RETRY_EN net_rst_o=1 for 8 cycles and then drops again; without it state_o=3 and stays there for 200 cycles.
REQ-029 In RUN, pulse net_resetdone_i low for 5 cycles -> within 3 edges sys_rst_o=1, ready_o=0, state_o=0, followed by a full re-sequence.
REQ-030 Assert areset_i asynchronously mid-HOLD and mid-NET_WAIT -> all outputs reach reset values with no clock edge; timeout_o is cleared.
REQ-031 Drive resetdone rising so the synchronized value arrives at counter=31 -> RUN is entered and timeout_o stays 0.
